// File: rtl/mdu_if.sv
// MDU E-stage bus: operation control, operands and results.
// master drives the operation, slave is the MDU itself.
interface mdu_if;
  logic [3:0]  mdu_ctrl_E;
  logic [31:0] A_E;
  logic [31:0] B_E;
  logic        cancel_E;
  logic        start_E;
  logic        busy_E;
  logic        busy_start_E;
  logic [31:0] mdu_rdata_E;

  modport master (
    output mdu_ctrl_E, A_E, B_E, cancel_E,
    input  start_E, busy_E, busy_start_E, mdu_rdata_E
  );

  modport slave (
    input  mdu_ctrl_E, A_E, B_E, cancel_E,
    output start_E, busy_E, busy_start_E, mdu_rdata_E
  );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit with private HI/LO registers.
// Results are computed at start and committed after a fixed busy period.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset_n,
  mdu_if.slave bus
);
  localparam int CW = 16;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_dz;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_sh_hi;
  logic [31:0]   r_sh_lo;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_idle_ok;
  logic        w_start;
  logic        w_wr_hi;
  logic        w_wr_lo;
  logic        w_dz;
  logic        w_ovf;
  logic [31:0] w_sdvs;
  logic [31:0] w_udvs;
  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic [31:0] w_rdata;

  assign w_is_mul  = (bus.mdu_ctrl_E == 4'd1) | (bus.mdu_ctrl_E == 4'd2);
  assign w_is_div  = (bus.mdu_ctrl_E == 4'd3) | (bus.mdu_ctrl_E == 4'd4);
  assign w_idle_ok = !bus.cancel_E & !r_busy;
  assign w_start   = (w_is_mul | w_is_div) & w_idle_ok;
  assign w_wr_hi   = (bus.mdu_ctrl_E == 4'd7) & w_idle_ok;
  assign w_wr_lo   = (bus.mdu_ctrl_E == 4'd8) & w_idle_ok;

  // Divisor forced to 1 on /0 and on MIN/-1: the latter then
  // naturally yields quotient 0x80000000, remainder 0.
  assign w_ovf  = (bus.A_E == 32'h8000_0000) & (bus.B_E == 32'hFFFF_FFFF);
  assign w_sdvs = ((bus.B_E == 32'd0) | w_ovf) ? 32'd1 : bus.B_E;
  assign w_udvs = (bus.B_E == 32'd0) ? 32'd1 : bus.B_E;

  assign w_smul = {{32{bus.A_E[31]}}, bus.A_E} * {{32{bus.B_E[31]}}, bus.B_E};
  assign w_umul = {32'd0, bus.A_E} * {32'd0, bus.B_E};
  assign w_sq   = $signed(bus.A_E) / $signed(w_sdvs);
  assign w_sr   = $signed(bus.A_E) % $signed(w_sdvs);
  assign w_uq   = bus.A_E / w_udvs;
  assign w_ur   = bus.A_E % w_udvs;

  // Select the pending HI/LO result for the starting operation.
  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_dz     = 1'b0;
    case (bus.mdu_ctrl_E)
      4'd1:    {w_res_hi, w_res_lo} = w_smul;
      4'd2:    {w_res_hi, w_res_lo} = w_umul;
      4'd3: begin
        w_dz     = (bus.B_E == 32'd0);
        w_res_hi = w_sr;
        w_res_lo = w_sq;
      end
      4'd4: begin
        w_dz     = (bus.B_E == 32'd0);
        w_res_hi = w_ur;
        w_res_lo = w_uq;
      end
      default: ;
    endcase
  end

  // IDLE/BUSY sequencer, shadow results and HI/LO commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_sh_hi <= 32'd0;
      r_sh_lo <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_BUSY;
            r_busy  <= 1'b1;
            r_cnt   <= w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            r_sh_hi <= w_res_hi;
            r_sh_lo <= w_res_lo;
            r_dz    <= w_dz;
          end
          if (w_wr_hi) r_hi <= bus.A_E;
          if (w_wr_lo) r_lo <= bus.A_E;
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (!r_dz) begin
              r_hi <= r_sh_hi;
              r_lo <= r_sh_lo;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Move-from read path straight off the architectural registers.
  always_comb begin
    w_rdata = 32'd0;
    case (bus.mdu_ctrl_E)
      4'd5:    w_rdata = r_hi;
      4'd6:    w_rdata = r_lo;
      default: ;
    endcase
  end

  assign bus.start_E      = w_start;
  assign bus.busy_E       = r_busy;
  assign bus.busy_start_E = w_start | r_busy;
  assign bus.mdu_rdata_E  = w_rdata;
endmodule
